// File: rtl/tdm_demux4_if.sv
// ============================================================================
// tdm_demux4_if : serial beat input / parallel word output bundle  | Rev 1.0
// Macro TDM_DEMUX_PARITY_EN widens sel_out to cover the parity slot.
// ============================================================================
`default_nettype none

interface tdm_demux4_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 1
);
`ifdef TDM_DEMUX_PARITY_EN
   localparam int SEL_W = $clog2(LANES + 1);
`else
   localparam int SEL_W = $clog2(LANES);
`endif

   logic [DATA_W-1:0]       serial_in;
   logic                    valid_in;
   logic                    sync_in;
   logic [LANES*DATA_W-1:0] data_out;
   logic                    valid_out;
   logic [SEL_W-1:0]        sel_out;
   logic                    locked_out;
   logic                    err_out;

   modport master (
      output serial_in, valid_in, sync_in,
      input  data_out, valid_out, sel_out, locked_out, err_out
   );

   modport slave (
      input  serial_in, valid_in, sync_in,
      output data_out, valid_out, sel_out, locked_out, err_out
   );
endinterface

`default_nettype wire

// File: rtl/tdm_demux4.sv
// ============================================================================
// tdm_demux4 : TDM slot demultiplexer with frame-sync lock          | Rev 1.0
// Macro TDM_DEMUX_PARITY_EN adds an XOR parity beat after the last lane.
// ============================================================================
`default_nettype none

module tdm_demux4 #(
   parameter int LANES  = 4,
   parameter int DATA_W = 1
) (
   input  wire logic    clk_in,
   input  wire logic    rst_n_in,
   tdm_demux4_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int SEL_W      = $clog2(LANES + 1);
   localparam int FRAME_LAST = LANES;
`else
   localparam int SEL_W      = $clog2(LANES);
   localparam int FRAME_LAST = LANES - 1;
`endif

   localparam logic [0:0]       c_st_hunt   = 1'b0;
   localparam logic [0:0]       c_st_locked = 1'b1;
   localparam logic [SEL_W-1:0] c_sel_zero  = '0;
   localparam logic [SEL_W-1:0] c_sel_one   = SEL_W'(1);
   localparam logic [SEL_W-1:0] c_sel_last  = SEL_W'(FRAME_LAST);

   logic [0:0]              r_state;
   logic [SEL_W-1:0]        r_sel;
   logic [LANES*DATA_W-1:0] r_shadow;
   logic [LANES*DATA_W-1:0] r_data;
   logic                    r_valid;
   logic                    r_err;

   logic [0:0]              w_state_nxt;
   logic [SEL_W-1:0]        w_sel_nxt;
   logic                    w_wr_en;
   logic [SEL_W-1:0]        w_wr_idx;
   logic                    w_frame_done;
   logic                    w_sync_err;
   logic                    w_par_err;
   logic [LANES*DATA_W-1:0] w_shadow_nxt;
   logic [LANES*DATA_W-1:0] w_data_nxt;
   logic                    w_valid_nxt;
   logic                    w_err_nxt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state  <= c_st_hunt;
         r_sel    <= c_sel_zero;
         r_shadow <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_shadow <= w_shadow_nxt;
         r_data   <= w_data_nxt;
         r_valid  <= w_valid_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // A sync beat always lands in lane 0, whether it opens a frame or aborts one.
   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_wr_en      = 1'b0;
      w_wr_idx     = r_sel;
      w_frame_done = 1'b0;
      w_sync_err   = 1'b0;
      if (bus.valid_in) begin
         if (bus.sync_in) begin
            w_wr_idx = c_sel_zero;
         end
         case (r_state)
            c_st_hunt: begin
               if (bus.sync_in) begin
                  w_state_nxt = c_st_locked;
                  w_sel_nxt   = c_sel_one;
                  w_wr_en     = 1'b1;
               end
            end
            default: begin
               if (bus.sync_in) begin
                  w_wr_en    = 1'b1;
                  w_sel_nxt  = c_sel_one;
                  w_sync_err = (r_sel != c_sel_zero);
               end else if (r_sel == c_sel_zero) begin
                  w_sync_err  = 1'b1;
                  w_state_nxt = c_st_hunt;
                  w_sel_nxt   = c_sel_zero;
               end else if (r_sel == c_sel_last) begin
                  w_wr_en      = 1'b1;
                  w_frame_done = 1'b1;
                  w_sel_nxt    = c_sel_zero;
               end else begin
                  w_wr_en   = 1'b1;
                  w_sel_nxt = r_sel + c_sel_one;
               end
            end
         endcase
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   logic [DATA_W-1:0] w_lane_xor;

   always_comb begin
      w_lane_xor = '0;
      for (int k = 0; k < LANES; k++) begin
         w_lane_xor = w_lane_xor ^ r_shadow[k*DATA_W +: DATA_W];
      end
   end
`endif

   // The parity slot index is LANES, so it never matches a shadow lane.
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (w_wr_en) begin
         for (int k = 0; k < LANES; k++) begin
            if (w_wr_idx == SEL_W'(k)) begin
               w_shadow_nxt[k*DATA_W +: DATA_W] = bus.serial_in;
            end
         end
      end
`ifdef TDM_DEMUX_PARITY_EN
      w_par_err = w_frame_done && (w_lane_xor != bus.serial_in);
`else
      w_par_err = 1'b0;
`endif
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      if (w_frame_done && !w_par_err) begin
         w_data_nxt  = w_shadow_nxt;
         w_valid_nxt = 1'b1;
      end
      w_err_nxt = w_sync_err | w_par_err;
   end

   assign bus.data_out   = r_data;
   assign bus.valid_out  = r_valid;
   assign bus.sel_out    = r_sel;
   assign bus.locked_out = (r_state == c_st_locked);
   assign bus.err_out    = r_err;

endmodule

`default_nettype wire

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Time-division demultiplexer: the receive end of a slot-multiplexed serial link where a transmitter rotates its select across lanes and emits one lane sample per beat. Tracks the slot position from a frame-sync marker and steers each beat into its lane. Presents the reassembled parallel word with a one-cycle valid pulse. Sits downstream of the 4:1 mux path in the combinational-circuits library, restoring parallel lane data.

Parameters:
LANES, 4, number of lanes / slots per frame (>=2)
DATA_W, 1, bits per slot sample
SEL_W, $clog2(LANES), slot index width (derived, not overridden)

Ports:
clk_in  input  1  single clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
serial_in  input  DATA_W  slot sample
valid_in  input  1  serial_in/sync_in valid this cycle (beat)
sync_in  input  1  marks beat as slot 0 of a frame; sampled only with valid_in
data_out  output  LANES*DATA_W  reassembled word; slot k at [k*DATA_W +: DATA_W]
valid_out  output  1  one-cycle pulse: data_out updated
sel_out  output  SEL_W  slot index expected on next beat
locked_out  output  1  1 when in LOCKED
err_out  output  1  one-cycle pulse on framing/parity error

Behaviour:
- Interface: one clock clk_in; reset rst_n_in is asynchronous, active-low.
- Reset, asynchronous, mid-operation included: data_out=0, valid_out=0, sel_out=0, locked_out=0, err_out=0, state=HUNT, shadow lanes=0, partial frame discarded.
- All outputs are registered. No beat occurs when valid_in=0: state, sel_out and shadow hold; valid_out/err_out are 0.
- HUNT: beats with sync_in=0 are dropped. A beat with sync_in=1 writes shadow lane 0, sets sel_out=1 and moves to LOCKED.
- LOCKED, beat with sync_in matching the slot (1 at slot 0, 0 elsewhere): write shadow[sel_out], sel_out+1.
- Last slot (sel_out=LANES-1): the next edge loads data_out with the shadow plus the final sample, pulses valid_out and wraps sel_out to 0. Latency is 1 cycle from the last beat to valid_out.
- sync_in=1 at slot !=0: pulse err_out, discard the partial frame, and take the beat as slot 0 of a new frame (sel_out=1). Remain in LOCKED.
- sync_in=0 at slot 0: pulse err_out, drop the beat and go to HUNT. sel_out=0, locked_out=0.
- data_out holds its value between frames. It changes only together with valid_out.
- valid_out and err_out are never asserted in the same cycle.
- Back-to-back frames (valid_in continuously 1) are sustained at full rate: one valid_out every LANES cycles.

Optional Feature:
Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - A frame is LANES+1 beats. The extra beat, at slot index LANES, carries the bitwise XOR of all LANES samples.
  - SEL_W widens to cover index LANES.
  - After the parity beat: on match, data_out/valid_out update as above. On mismatch, err_out pulses, data_out holds, no valid_out, and the block stays LOCKED expecting slot 0.
  - sync rules apply to the parity slot like any non-zero slot.
- Undefined: a frame is LANES beats; no parity logic is present.

Test Plan:
1. LANES=4, DATA_W=1. Sync frame with beats 1,0,1,1 -> data_out=4'b1101; valid_out high exactly one cycle, the cycle after beat 4; locked_out=1; sel_out=0.
2. Same frame with 3 idle cycles (valid_in=0) between beats -> data_out=4'b1101, a single valid_out pulse, sel_out stepping 1,2,3,0.
3. Frame start, then sync_in=1 on slot 2 followed by beats 1,1,0 -> err_out pulse, no valid_out; then data_out=4'b0110 (slot0=0, slot1=1, slot2=1, slot3=0).
4. Beat at slot 0 with sync_in=0 while LOCKED -> err_out pulse, locked_out=0; following non-sync beats are ignored; the next sync beat relocks.
5. rst_n_in low asynchronously mid-frame (between edges) -> all outputs 0 immediately. After release, beats without sync are ignored.
6. TDM_DEMUX_PARITY_EN defined:
   - Beats 1,1,0,0 with parity 0 -> data_out=4'b0011, valid_out pulse.
   - Same beats with parity 1 -> err_out pulse, data_out unchanged.
